// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 constants, decoder state and key event types.
package ps2_pkg;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;
    localparam logic [7:0] PS2_ERR_00  = 8'h00;
    localparam logic [7:0] PS2_ERR_FF  = 8'hFF;

    localparam int PS2_EV_W = 10;

    typedef enum logic [1:0] {
        DEC_IDLE,
        DEC_E0,
        DEC_F0,
        DEC_E0F0
    } ps2_dec_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_key_event_t;

    // Saturating 8-bit increment for the status counters.
    function automatic logic [7:0] ps2_sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word fall-through event FIFO; a push into a full FIFO is dropped
// unless a pop happens in the same cycle.
module ps2_event_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic         o_empty,
    output logic [W-1:0] o_head,
    output logic         o_drop
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == CNT_FULL);
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop);
    assign o_drop    = i_push & w_full & ~w_do_pop;
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 set-2 scan-code sequencer: prefix FSM, event FIFO, error/drop counters.
// Optional typematic repeat filter: define PS2_KEY_CTRL_REPEAT_FILTER_EN.
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       pending,
    output logic [7:0] drop_cnt,
    output logic [7:0] err_cnt
);

    localparam int          TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    ps2_dec_state_t r_state;
    ps2_dec_state_t w_next_state;
    logic [TW-1:0]  r_timer;
    logic [7:0]     r_err_cnt;
    logic [7:0]     r_drop_cnt;

    logic           w_is_err;
    logic           w_is_ext;
    logic           w_is_brk;
    logic           w_emit;
    logic           w_push;
    logic           w_timeout;
    logic           w_empty;
    logic           w_drop;
    ps2_key_event_t w_ev;
    ps2_key_event_t w_head;

    assign w_is_err  = (rx_data == PS2_ERR_00) || (rx_data == PS2_ERR_FF);
    assign w_is_ext  = (rx_data == PS2_PFX_EXT);
    assign w_is_brk  = (rx_data == PS2_PFX_BRK);
    assign w_timeout = ~rx_valid && (r_state != DEC_IDLE) && (r_timer == TO_LAST);

    always_comb begin
        w_next_state = r_state;
        w_emit       = 1'b0;
        w_ev         = '0;
        w_ev.code    = rx_data;
        if (rx_valid) begin
            if (w_is_err) begin
                w_next_state = DEC_IDLE;
            end else begin
                case (r_state)
                    DEC_IDLE: begin
                        if (w_is_ext)      w_next_state = DEC_E0;
                        else if (w_is_brk) w_next_state = DEC_F0;
                        else               w_emit = 1'b1;
                    end
                    DEC_E0: begin
                        if (w_is_brk)      w_next_state = DEC_E0F0;
                        else if (!w_is_ext) begin
                            w_emit       = 1'b1;
                            w_ev.ext     = 1'b1;
                            w_next_state = DEC_IDLE;
                        end
                    end
                    DEC_F0: begin
                        if (w_is_ext)      w_next_state = DEC_E0F0;
                        else if (!w_is_brk) begin
                            w_emit       = 1'b1;
                            w_ev.brk     = 1'b1;
                            w_next_state = DEC_IDLE;
                        end
                    end
                    default: begin
                        if (!w_is_ext && !w_is_brk) begin
                            w_emit       = 1'b1;
                            w_ev.ext     = 1'b1;
                            w_ev.brk     = 1'b1;
                            w_next_state = DEC_IDLE;
                        end
                    end
                endcase
            end
        end else if (w_timeout) begin
            w_next_state = DEC_IDLE;
        end
    end

`ifdef PS2_KEY_CTRL_REPEAT_FILTER_EN
    logic [8:0] r_flt_key;
    logic       r_flt_vld;
    logic       w_flt_hit;

    // A repeated make of the held key is typematic and is swallowed silently.
    assign w_flt_hit = r_flt_vld && (r_flt_key == {w_ev.ext, w_ev.code});
    assign w_push    = w_emit & ~(~w_ev.brk & w_flt_hit);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_flt_vld <= 1'b0;
            r_flt_key <= '0;
        end else if (w_emit) begin
            if (!w_ev.brk) begin
                r_flt_vld <= 1'b1;
                r_flt_key <= {w_ev.ext, w_ev.code};
            end else if (w_flt_hit) begin
                r_flt_vld <= 1'b0;
            end
        end
    end
`else
    assign w_push = w_emit;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= DEC_IDLE;
            r_timer    <= '0;
            r_err_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (rx_valid || r_state == DEC_IDLE || w_timeout)
                r_timer <= '0;
            else
                r_timer <= r_timer + TW'(1);
            if ((rx_valid && w_is_err) || w_timeout)
                r_err_cnt <= ps2_sat_inc(r_err_cnt);
            if (w_drop)
                r_drop_cnt <= ps2_sat_inc(r_drop_cnt);
        end
    end

    ps2_event_fifo #(
        .DEPTH (DEPTH),
        .W     (PS2_EV_W)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_data  (w_ev),
        .i_pop   (ev_ready),
        .o_empty (w_empty),
        .o_head  (w_head),
        .o_drop  (w_drop)
    );

    assign ev_valid = ~w_empty;
    assign ev_code  = w_head.code;
    assign ev_ext   = w_head.ext;
    assign ev_break = w_head.brk;
    assign pending  = (r_state != DEC_IDLE);
    assign drop_cnt = r_drop_cnt;
    assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed self-checking bench for ps2_key_ctrl (DEPTH=8, short timeout).
module tb_ps2_key_ctrl;

    localparam int DEPTH = 8;
    localparam int TO    = 16;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       ev_ready = 1'b0;
    logic       ev_valid, ev_ext, ev_break, pending;
    logic [7:0] ev_code, drop_cnt, err_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ps2_key_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_code  (ev_code),
        .ev_ext   (ev_ext),
        .ev_break (ev_break),
        .pending  (pending),
        .drop_cnt (drop_cnt),
        .err_cnt  (err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Check the head against {ext,brk,code} then pop it.
    task automatic pop_chk(input string tag, input logic [9:0] exp);
        chk({tag, "_vld"}, 32'(ev_valid), 32'd1);
        chk({tag, "_ev"}, 32'({ev_ext, ev_break, ev_code}), 32'(exp));
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
    endtask

    initial begin
        // reset
        repeat (2) @(negedge clk);
        chk("rst_vld",  32'(ev_valid), 32'd0);
        chk("rst_code", 32'(ev_code),  32'd0);
        chk("rst_ext",  32'(ev_ext),   32'd0);
        chk("rst_brk",  32'(ev_break), 32'd0);
        chk("rst_pend", 32'(pending),  32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_err",  32'(err_cnt),  32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // make / break
        send(8'h1C);
        chk("mk_lat", 32'(ev_valid), 32'd1);
        pop_chk("mk", 10'h01C);
        chk("mk_empty", 32'(ev_valid), 32'd0);
        send(8'hF0);
        chk("brk_pend", 32'(pending), 32'd1);
        chk("brk_noev", 32'(ev_valid), 32'd0);
        send(8'h1C);
        chk("brk_pend0", 32'(pending), 32'd0);
        pop_chk("brk", 10'h11C);

        // extended
        send(8'hE0);
        chk("emk_pend", 32'(pending), 32'd1);
        send(8'h75);
        pop_chk("emk", 10'h275);
        send(8'hE0);
        send(8'hF0);
        chk("ebrk_pend", 32'(pending), 32'd1);
        chk("ebrk_noev", 32'(ev_valid), 32'd0);
        send(8'h75);
        pop_chk("ebrk", 10'h375);

        // overflow: DEPTH+2 distinct makes back-to-back
        for (int i = 0; i < DEPTH + 2; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'h10 + 8'(i);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        chk("ovf_vld",  32'(ev_valid), 32'd1);
        chk("ovf_drop", 32'(drop_cnt), 32'd2);
        chk("ovf_head", 32'({ev_ext, ev_break, ev_code}), 32'h010);
        // push and pop while full
        rx_valid = 1'b1;
        rx_data  = 8'h2A;
        ev_ready = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        ev_ready = 1'b0;
        chk("pp_drop", 32'(drop_cnt), 32'd2);
        for (int i = 1; i < DEPTH; i++)
            pop_chk("drain", 10'(8'h10 + 8'(i)));
        pop_chk("drain_last", 10'h02A);
        chk("drain_empty", 32'(ev_valid), 32'd0);

        // timeout
        send(8'hE0);
        repeat (TO - 1) @(negedge clk);
        chk("to_pend1", 32'(pending), 32'd1);
        chk("to_err0",  32'(err_cnt), 32'd0);
        @(negedge clk);
        chk("to_pend0", 32'(pending), 32'd0);
        chk("to_err1",  32'(err_cnt), 32'd1);

        // overrun byte
        send(8'hF0);
        send(8'hFF);
        chk("ovr_noev", 32'(ev_valid), 32'd0);
        chk("ovr_err",  32'(err_cnt),  32'd2);
        chk("ovr_pend", 32'(pending),  32'd0);

        // typematic repeat
        send(8'h1C); send(8'h1C); send(8'h1C);
        send(8'hF0); send(8'h1C); send(8'h1C);
`ifdef PS2_KEY_CTRL_REPEAT_FILTER_EN
        pop_chk("rep0", 10'h01C);
        pop_chk("rep1", 10'h11C);
        pop_chk("rep2", 10'h01C);
`else
        pop_chk("rep0", 10'h01C);
        pop_chk("rep1", 10'h01C);
        pop_chk("rep2", 10'h01C);
        pop_chk("rep3", 10'h11C);
        pop_chk("rep4", 10'h01C);
`endif
        chk("rep_empty", 32'(ev_valid), 32'd0);

        // reset mid-sequence with a queued event
        send(8'h33);
        send(8'hE0);
        send(8'hF0);
        resetn = 1'b0;
        @(negedge clk);
        chk("mrst_vld",  32'(ev_valid), 32'd0);
        chk("mrst_code", 32'(ev_code),  32'd0);
        chk("mrst_pend", 32'(pending),  32'd0);
        chk("mrst_err",  32'(err_cnt),  32'd0);
        chk("mrst_drop", 32'(drop_cnt), 32'd0);
        resetn = 1'b1;
        send(8'h1C);
        pop_chk("mrst_mk", 10'h01C);
        chk("mrst_empty", 32'(ev_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
